// File: rtl/rr_sel_pkg.sv
// rtl/rr_sel_pkg.sv - shared types and helpers for the round-robin select arbiter
package rr_sel_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Beat counter needs at least one bit even when BURST is 1.
  function automatic int cnt_width(input int burst);
    return (burst > 1) ? $clog2(burst) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - first active request at or after ptr, wrapping modulo 2**N
module rr_pick #(
  parameter int N = 3
) (
  input  logic [2**N-1:0] req,
  input  logic [N-1:0]    ptr,
  output logic [N-1:0]    idx,
  output logic            found
);

  localparam int M = 2**N;

  logic [N-1:0] cand;

  // Scan from the far end back toward ptr so the closest hit is written last.
  always_comb begin
    idx   = ptr;
    found = 1'b0;
    cand  = '0;
    for (int k = M - 1; k >= 0; k--) begin
      cand = ptr + N'(k);
      if (req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_sel_arbiter.sv
// rtl/rr_sel_arbiter.sv - round-robin arbiter driving the mux select, with per-grant burst limit
module rr_sel_arbiter
  import rr_sel_pkg::*;
#(
  parameter int N     = 3,
  parameter int BURST = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2**N-1:0] req,
  output logic [2**N-1:0] req_ready,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [N-1:0]    sel,
  output logic [2**N-1:0] grant
);

  localparam int M  = 2**N;
  localparam int CW = cnt_width(BURST);
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST - 1);

  arb_state_t   state;
  logic [N-1:0] ptr;
  logic [CW-1:0] cnt;

  logic         busy;
  logic         owner_req;
  logic         transfer;
  logic         release_owner;
  logic [N-1:0] ptr_nxt;
  logic [N-1:0] pick_idx;
  logic         pick_found;
  logic [M-1:0] pick_onehot;

  assign busy      = (state == BUSY);
  assign owner_req = req[sel];
  assign out_valid = busy && owner_req;
  assign req_ready = grant & {M{out_ready && busy}};
  assign transfer  = out_valid && out_ready;

  assign release_owner = busy && (!owner_req || (transfer && (cnt == CNT_LAST)));

  // Releasing owner moves priority past itself before the same-cycle re-pick.
  assign ptr_nxt = release_owner ? (sel + N'(1)) : ptr;

  rr_pick #(
    .N(N)
  ) u_pick (
    .req  (req),
    .ptr  (ptr_nxt),
    .idx  (pick_idx),
    .found(pick_found)
  );

  assign pick_onehot = M'(1) << pick_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sel   <= '0;
      grant <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      ptr <= ptr_nxt;
      case (state)
        IDLE: begin
          if (pick_found) begin
            state <= BUSY;
            sel   <= pick_idx;
            grant <= pick_onehot;
            cnt   <= '0;
          end
        end
        BUSY: begin
          if (release_owner) begin
            cnt <= '0;
            if (pick_found) begin
              sel   <= pick_idx;
              grant <= pick_onehot;
            end else begin
              state <= IDLE;
              grant <= '0;
            end
          end else if (transfer) begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

endmodule
